decode_sequencer: RTL and testbench

- Run-level controller for a stochastic decoder built from equality nodes with edge memories (EMs).
- Sequences each codeword decode through three phases:
  - Init: drives the nodes' INIT line and walks EM addresses so every EM slot is loaded with channel bits.
  - Decode: generates the pseudo-random EM_SEL address stream and gates the decoding clock.
  - Termination: stops on parity-check convergence or on an iteration cap.
- Sits between the host/test harness and the node array; one instance drives all nodes.

---
 rtl/decode_pkg.sv | 29 ++
 rtl/lfsr16.sv | 27 ++
 rtl/decode_sequencer.sv | 163 ++++++++++++++++
 tb/tb_decode_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the stochastic decoder control path.
// Provides the sequencer state enum, the 16-bit LFSR polynomial,
// the default seed and the LFSR step helpers used by lfsr16 and
// by the sequencer's look-ahead EM_SEL register.
package decode_pkg;

  // Run-level phases of one codeword decode
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INIT   = 2'd1,
    S_DECODE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1 on a shift-left register: bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // One Fibonacci step: XOR of the tapped bits enters at bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

  // All-zero is the lock-up state, so it is never loaded
  function automatic logic [15:0] lfsr_fix_seed(input logic [15:0] s);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left.
// Ports:
//   CLK   in   clock
//   RST   in   synchronous active-high reset, loads SEED (0 -> 1)
//   EN    in   advance one step this cycle
//   SEED  in   reset value
//   Q     out  current register contents
module lfsr16
  import decode_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [15:0] SEED,
  output logic [15:0] Q
);

  // State register; holds when EN is low
  always_ff @(posedge CLK) begin
    if (RST) begin
      Q <= lfsr_fix_seed(SEED);
    end else if (EN) begin
      Q <= lfsr_next(Q);
    end
  end

endmodule

// File: rtl/decode_sequencer.sv
// Run-level controller for a stochastic equality-node decoder.
// Each codeword goes through INIT (loads every edge-memory slot while
// walking EM addresses), DECODE (pseudo-random EM_SEL stream, node clock
// enabled) and terminates on settled parity or on the iteration cap.
// Ports:
//   CLK        in   clock, shared with the node array
//   RST        in   synchronous active-high reset
//   START      in   begin a decode (honoured in IDLE and DONE)
//   ABORT      in   cancel a decode in INIT or DECODE
//   PARITY_OK  in   AND of all check-node outputs
//   INIT       out  node INIT line
//   RUN        out  node-array clock enable
//   EM_SEL     out  EM address to all nodes
//   BUSY       out  high in INIT and DECODE
//   DONE       out  high in DONE
//   CONVERGED  out  result flag, valid while DONE
//   ITER_CNT   out  decode cycles used
module decode_sequencer
  import decode_pkg::*;
#(
  parameter int unsigned EM_AW     = 3,
  parameter int unsigned INIT_CYC  = 8,
  parameter int unsigned MAX_ITER  = 1024,
  parameter int unsigned ITER_W    = 16,
  parameter int unsigned SETTLE    = 4,
  parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic              PARITY_OK,
  output logic              INIT,
  output logic              RUN,
  output logic [EM_AW-1:0]  EM_SEL,
  output logic              BUSY,
  output logic              DONE,
  output logic              CONVERGED,
  output logic [ITER_W-1:0] ITER_CNT
);

  localparam int unsigned INIT_W = $clog2(INIT_CYC + 1);
  localparam int unsigned OK_W   = 8;

  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYC - 1);
  localparam logic [ITER_W-1:0] ITER_CAP  = ITER_W'(MAX_ITER);
  localparam logic [OK_W-1:0]   OK_GOAL   = OK_W'(SETTLE);
  localparam logic [OK_W-1:0]   OK_SAT    = '1;

  state_t              r_state;
  logic [INIT_W-1:0]   r_init_cnt;
  logic [OK_W-1:0]     r_ok_cnt;

  logic [15:0]         w_lfsr;
  logic [15:0]         w_lfsr_nxt;
  logic                w_lfsr_en;
  logic [INIT_W-1:0]   w_init_nxt;
  logic [ITER_W-1:0]   w_iter_nxt;
  logic [OK_W-1:0]     w_ok_nxt;
  logic                w_conv_hit;
  logic                w_cap_hit;

  // LFSR steps on every DECODE cycle that is not cancelled
  assign w_lfsr_en  = (r_state == S_DECODE) && !ABORT;
  assign w_lfsr_nxt = lfsr_next(w_lfsr);

  lfsr16 u_lfsr (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (w_lfsr_en),
    .SEED (LFSR_SEED),
    .Q    (w_lfsr)
  );

  // Incremented counters; termination is judged on these values
  assign w_init_nxt = r_init_cnt + INIT_W'(1);
  assign w_iter_nxt = ITER_CNT + ITER_W'(1);
  assign w_ok_nxt   = !PARITY_OK          ? '0 :
                      (r_ok_cnt == OK_SAT) ? r_ok_cnt :
                                             r_ok_cnt + OK_W'(1);
  assign w_conv_hit = (w_ok_nxt == OK_GOAL);
  assign w_cap_hit  = (w_iter_nxt == ITER_CAP);

  // Sequencer FSM with registered outputs; EM_SEL is loaded one cycle
  // ahead so it matches the address the nodes see in the current cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_init_cnt <= '0;
      r_ok_cnt   <= '0;
      INIT       <= 1'b0;
      RUN        <= 1'b0;
      EM_SEL     <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      CONVERGED  <= 1'b0;
      ITER_CNT   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (START) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
            r_ok_cnt   <= '0;
            INIT       <= 1'b1;
            RUN        <= 1'b1;
            EM_SEL     <= '0;
            BUSY       <= 1'b1;
            DONE       <= 1'b0;
            CONVERGED  <= 1'b0;
            ITER_CNT   <= '0;
          end
        end

        S_INIT: begin
          if (ABORT) begin
            r_state <= S_IDLE;
            INIT    <= 1'b0;
            RUN     <= 1'b0;
            BUSY    <= 1'b0;
            EM_SEL  <= '0;
          end else if (r_init_cnt == INIT_LAST) begin
            // LFSR has not moved during INIT, so its current value is the first address
            r_state <= S_DECODE;
            INIT    <= 1'b0;
            EM_SEL  <= w_lfsr[EM_AW-1:0];
          end else begin
            r_init_cnt <= w_init_nxt;
            EM_SEL     <= w_init_nxt[EM_AW-1:0];
          end
        end

        S_DECODE: begin
          if (ABORT) begin
            // ITER_CNT deliberately kept for post-mortem inspection
            r_state <= S_IDLE;
            RUN     <= 1'b0;
            BUSY    <= 1'b0;
            EM_SEL  <= '0;
          end else begin
            ITER_CNT <= w_iter_nxt;
            r_ok_cnt <= w_ok_nxt;
            if (w_conv_hit || w_cap_hit) begin
              // Convergence wins a tie with the cap; EM_SEL holds the last address
              r_state   <= S_DONE;
              RUN       <= 1'b0;
              BUSY      <= 1'b0;
              DONE      <= 1'b1;
              CONVERGED <= w_conv_hit;
            end else begin
              EM_SEL <= w_lfsr_nxt[EM_AW-1:0];
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_sequencer.sv
// Scoreboard bench for decode_sequencer: the stimulus side predicts every
// cycle's outputs from a codeword-level model and queues them; a monitor
// pops one expectation per cycle and compares it with the DUT.
module tb_decode_sequencer;

  localparam int unsigned EM_AW    = 3;
  localparam int unsigned INIT_CYC = 8;
  localparam int unsigned MAX_ITER = 20;
  localparam int unsigned ITER_W   = 16;
  localparam int unsigned SETTLE   = 4;
  localparam logic [15:0] SEED     = 16'hACE1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic              parity_ok;
  logic              init_o;
  logic              run_o;
  logic [EM_AW-1:0]  em_sel;
  logic              busy_o;
  logic              done_o;
  logic              conv_o;
  logic [ITER_W-1:0] iter_cnt;

  always #5 clk = ~clk;

  decode_sequencer #(
    .EM_AW     (EM_AW),
    .INIT_CYC  (INIT_CYC),
    .MAX_ITER  (MAX_ITER),
    .ITER_W    (ITER_W),
    .SETTLE    (SETTLE),
    .LFSR_SEED (SEED)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .START     (start),
    .ABORT     (abort),
    .PARITY_OK (parity_ok),
    .INIT      (init_o),
    .RUN       (run_o),
    .EM_SEL    (em_sel),
    .BUSY      (busy_o),
    .DONE      (done_o),
    .CONVERGED (conv_o),
    .ITER_CNT  (iter_cnt)
  );

  typedef struct packed {
    logic              init;
    logic              run;
    logic [EM_AW-1:0]  em;
    logic              busy;
    logic              done;
    logic              conv;
    logic [ITER_W-1:0] iter;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // Reference state: LFSR value the next DECODE cycle will use, and what
  // the outputs look like while nothing is happening (IDLE or DONE hold)
  logic [15:0] m_lfsr;
  exp_t        m_rest;
  bit          pat [1:MAX_ITER];

  function automatic logic [15:0] m_step(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  function automatic exp_t e_idle(input logic [ITER_W-1:0] it);
    return '{init: 1'b0, run: 1'b0, em: '0, busy: 1'b0, done: 1'b0, conv: 1'b0, iter: it};
  endfunction

  function automatic exp_t e_init(input int i);
    return '{init: 1'b1, run: 1'b1, em: EM_AW'(i), busy: 1'b1, done: 1'b0, conv: 1'b0, iter: '0};
  endfunction

  function automatic exp_t e_dec(input logic [EM_AW-1:0] em, input logic [ITER_W-1:0] it);
    return '{init: 1'b0, run: 1'b1, em: em, busy: 1'b1, done: 1'b0, conv: 1'b0, iter: it};
  endfunction

  function automatic exp_t e_done(input logic [EM_AW-1:0] em, input logic cv, input logic [ITER_W-1:0] it);
    return '{init: 1'b0, run: 1'b0, em: em, busy: 1'b0, done: 1'b1, conv: cv, iter: it};
  endfunction

  // Inputs are already set by the caller; after the edge queue what the DUT must show
  task automatic tick(input exp_t e, input string tag);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle
  exp_t  mon_e;
  exp_t  mon_a;
  string mon_t;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        mon_a = '{init: init_o, run: run_o, em: em_sel, busy: busy_o,
                  done: done_o, conv: conv_o, iter: iter_cnt};
        n_checks++;
        if (mon_a === mon_e) begin
          n_pass++;
        end else begin
          $display("FAIL %s @%0t: got init=%0b run=%0b em=%0d busy=%0b done=%0b conv=%0b iter=%0d, want init=%0b run=%0b em=%0d busy=%0b done=%0b conv=%0b iter=%0d",
                   mon_t, $time, mon_a.init, mon_a.run, mon_a.em, mon_a.busy, mon_a.done, mon_a.conv, mon_a.iter,
                   mon_e.init, mon_e.run, mon_e.em, mon_e.busy, mon_e.done, mon_e.conv, mon_e.iter);
        end
      end
    end
  end

  task automatic do_reset(input int n);
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (n) tick(e_idle('0), "reset");
    rst    = 1'b0;
    m_lfsr = SEED;
    m_rest = e_idle('0);
  endtask

  // Quiet cycles; with junk set, stray ABORT/PARITY_OK must change nothing
  task automatic hold_cycles(input int n, input bit junk);
    for (int i = 0; i < n; i++) begin
      start     = 1'b0;
      abort     = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      parity_ok = 1'($urandom_range(0, 1));
      tick(m_rest, "hold");
    end
    abort = 1'b0;
  endtask

  // One codeword using pat[]. abort_init: INIT cycle (1-based) with ABORT high;
  // abort_cyc: DECODE cycle (1-based) with ABORT high; rst_at: DECODE cycle with RST.
  // Zero disables each. noise drives stray START while busy.
  task automatic run_decode(input int abort_init, input int abort_cyc, input int rst_at,
                            input bit noise, input string name);
    int               term;
    bit               conv;
    int               run_len;
    logic [EM_AW-1:0] em_now;

    // Codeword outcome: first cycle ending SETTLE consecutive passes, else the cap
    term = MAX_ITER;
    conv = 1'b0;
    run_len = 0;
    for (int k = 1; k <= MAX_ITER; k++) begin
      run_len = pat[k] ? run_len + 1 : 0;
      if (run_len == SETTLE) begin
        term = k;
        conv = 1'b1;
        break;
      end
    end

    start     = 1'b1;
    abort     = 1'b0;
    parity_ok = 1'($urandom_range(0, 1));
    tick(e_init(0), {name, " start"});

    for (int i = 0; i < INIT_CYC; i++) begin
      start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      parity_ok = 1'($urandom_range(0, 1));
      if (abort_init == i + 1) begin
        abort = 1'b1;
        tick(e_idle('0), {name, " init-abort"});
        abort  = 1'b0;
        start  = 1'b0;
        m_rest = e_idle('0);
        return;
      end
      if (i < INIT_CYC - 1) tick(e_init(i + 1), {name, " init"});
      else                  tick(e_dec(m_lfsr[EM_AW-1:0], '0), {name, " first-decode"});
    end

    for (int k = 1; k <= term; k++) begin
      start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      parity_ok = pat[k];
      if (rst_at == k) begin
        rst = 1'b1;
        tick(e_idle('0), {name, " mid-reset"});
        rst    = 1'b0;
        start  = 1'b0;
        m_lfsr = SEED;
        m_rest = e_idle('0);
        return;
      end
      if (abort_cyc == k) begin
        abort = 1'b1;
        tick(e_idle(ITER_W'(k - 1)), {name, " abort"});
        abort  = 1'b0;
        start  = 1'b0;
        m_rest = e_idle(ITER_W'(k - 1));
        return;
      end
      em_now = m_lfsr[EM_AW-1:0];
      m_lfsr = m_step(m_lfsr);
      if (k == term) begin
        m_rest = e_done(em_now, conv, ITER_W'(k));
        tick(m_rest, {name, " done"});
      end else begin
        tick(e_dec(m_lfsr[EM_AW-1:0], ITER_W'(k)), {name, " decode"});
      end
    end
    start     = 1'b0;
    parity_ok = 1'b0;
  endtask

  task automatic fill_pat(input int from, input int to, input bit v);
    for (int k = from; k <= to; k++) pat[k] = v;
  endtask

  initial begin
    int d;
    int ai;
    int ac;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    parity_ok = 1'b0;
    m_lfsr    = SEED;
    m_rest    = e_idle('0);

    // Reset and quiet idle
    do_reset(2);
    hold_cycles(5, 1'b0);

    // Convergence after 1,1,0,1,1,1,1 -> ITER_CNT 7
    fill_pat(1, MAX_ITER, 1'b0);
    pat[1] = 1'b1; pat[2] = 1'b1; pat[3] = 1'b0;
    pat[4] = 1'b1; pat[5] = 1'b1; pat[6] = 1'b1; pat[7] = 1'b1;
    run_decode(0, 0, 0, 1'b0, "converge");
    hold_cycles(6, 1'b1);

    // Iteration cap with parity never passing
    fill_pat(1, MAX_ITER, 1'b0);
    run_decode(0, 0, 0, 1'b0, "cap");
    hold_cycles(3, 1'b1);

    // Settle completes exactly on the cap cycle
    fill_pat(1, MAX_ITER - SETTLE, 1'b0);
    fill_pat(MAX_ITER - SETTLE + 1, MAX_ITER, 1'b1);
    run_decode(0, 0, 0, 1'b0, "tie");
    hold_cycles(2, 1'b0);

    // Abort once three DECODE cycles have completed, then restart
    fill_pat(1, MAX_ITER, 1'b0);
    run_decode(0, 4, 0, 1'b0, "abort");
    hold_cycles(4, 1'b1);
    run_decode(0, 0, 0, 1'b0, "restart");
    hold_cycles(2, 1'b0);

    // Abort during INIT
    run_decode(5, 0, 0, 1'b0, "init-abort");
    hold_cycles(2, 1'b0);

    // Reset mid-decode reloads the LFSR
    run_decode(0, 0, 6, 1'b0, "rst-mid");
    hold_cycles(2, 1'b0);
    run_decode(0, 0, 0, 1'b0, "post-rst");
    hold_cycles(2, 1'b0);

    // Randomised codewords
    for (int n = 0; n < 40; n++) begin
      d = $urandom_range(0, 4);
      for (int k = 1; k <= MAX_ITER; k++) pat[k] = ($urandom_range(0, 3) < d);
      ai = ($urandom_range(0, 9) == 0) ? $urandom_range(1, INIT_CYC) : 0;
      ac = ($urandom_range(0, 5) == 0) ? $urandom_range(1, MAX_ITER) : 0;
      run_decode(ai, ac, 0, 1'($urandom_range(0, 1)), "random");
      hold_cycles($urandom_range(0, 3), 1'b1);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, want finish before %0t", $time);
    $fatal(1);
  end

endmodule
